atomic_unit: RTL and testbench
==============================

// Module: atomic_unit
// PURPOSE
//  Sequencer for RV32A instructions, placed between decode/execute and the data-memory port.
//  Runs the read-modify-write for AMOs: loads the word, drives atomic_alu, stores the result.
//  Implements LR/SC with a single-entry reservation.
//  Returns the rd value to writeback with a one-cycle o_done pulse.
// PARAMETERS
//  RESV_GRAN   2   log2 bytes of the reservation granule; address bits [XLEN-1:RESV_GRAN] are compared
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       synchronous, active-high reset
//  i_start        in   1       start request; sampled only in IDLE
//  i_op           in   5       funct5: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100,
//                              OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100
//  i_addr         in   XLEN    rs1 value (byte address)
//  i_rs2          in   XLEN    rs2 value
//  i_resv_clr     in   1       clear reservation (trap/xRET/context switch)
//  o_busy         out  1       high in every state except IDLE
//  o_done         out  1       one-cycle pulse; o_rd_data valid in the same cycle
//  o_rd_data      out  XLEN    value written to rd
//  o_mem_addr     out  XLEN    word address of the access, with bits [1:0] forced to 0
//  o_mem_rd       out  1       read request
//  o_mem_wr       out  1       write request (full word, all byte enables)
//  o_mem_wdata    out  XLEN    write data
//  i_mem_rdata    in   XLEN    read data; valid when i_mem_ack is high
//  i_mem_ack      in   1       access complete
//  o_alu_op       out  5       drives atomic_alu i_op; always equals the latched op
//  o_alu_s1       out  XLEN    drives atomic_alu s1; always equals the latched rs2
//  o_alu_s2       out  XLEN    drives atomic_alu s2; always equals the loaded memory word
//  i_alu_res      in   XLEN    atomic_alu alu_res
// BEHAVIOUR
//  - Reset: state=IDLE, reservation invalid. All outputs are 0: o_busy, o_done, o_mem_rd,
//    o_mem_wr, o_rd_data, o_mem_addr, o_mem_wdata and the alu operands.
//  - IDLE: when i_start=1, latch i_op, i_addr and i_rs2.
//      LR or AMO -> LOAD.
//      SC with a valid reservation and matching granule -> STORE.
//      SC otherwise -> DONE with rd=1.
//  - LOAD: hold o_mem_rd=1 and o_mem_addr until i_mem_ack=1, then latch i_mem_rdata as the loaded word.
//      LR: go to DONE; rd = loaded word; set the reservation on the granule.
//      AMO: go to STORE; rd = loaded word.
//  - STORE: hold o_mem_wr=1 until i_mem_ack=1, then go to DONE.
//      o_mem_wdata = i_alu_res for AMOs, i_rs2 for SC.
//      SC: rd=0. Any SC clears the reservation, whether it succeeds or fails.
//  - DONE: o_done=1 for exactly 1 cycle, then go to IDLE. o_rd_data holds until the next start.
//  - o_mem_rd and o_mem_wr are never high in the same cycle.
//    Requests and the latched operands stay stable until ack.
//  - Latency with a zero-wait memory (ack in the first request cycle):
//      AMO: o_done 3 cycles after i_start.
//      LR: 2 cycles after i_start.
//      Failed SC: 1 cycle after i_start.
//  - An AMO store that hits the reserved granule clears the reservation at its ack.
//  - i_resv_clr has priority over a reservation set in the same cycle:
//    the reservation ends invalid, and an SC in flight still completes.
//  - i_start while busy is ignored (not queued).
//  - Unknown i_op is treated as AMOSWAP.
//  - rst mid-operation: return to IDLE, drop requests next cycle, no o_done, reservation invalid.
// CONFIGURATION
//  ATOMIC_MISALIGN_EN defined:
//    - Adds output o_misaligned (1 bit), reset value 0.
//    - A start with i_addr[1:0]!=0 makes no memory access: DONE is taken with o_misaligned=1,
//      pulsed together with o_done. The reservation is unchanged and rd is not meaningful.
//  Not defined: the port is absent and i_addr[1:0] is ignored (the access is word-aligned).
// TESTING
//  - AMOADD addr 0x100, mem=5, rs2=3, zero-wait mem -> rd=5, mem[0x100]=8, o_done at cycle 3.
//  - AMOMIN mem=0xFFFFFFFF, rs2=1 -> mem=0xFFFFFFFF. AMOMINU with the same values -> mem=1.
//  - LR 0x200, then SC 0x200 rs2=7 -> SC rd=0, mem=7. A second SC -> rd=1, no write.
//  - LR 0x200, i_resv_clr pulse, SC 0x200 -> rd=1, o_mem_wr never asserted.
//  - AMOSWAP with ack delayed 4 cycles on both phases, rst asserted mid-STORE ->
//    IDLE next cycle, no o_done.
//  - ATOMIC_MISALIGN_EN defined: AMOOR at 0x102 -> o_misaligned=1 with o_done,
//    o_mem_rd and o_mem_wr stay 0.

Source files
------------

// File: rtl/atomic_unit.sv
// rtl/atomic_unit.sv - RV32A sequencer: AMO read-modify-write and LR/SC with a single reservation
//
// Optional feature macro: ATOMIC_MISALIGN_EN
//   defined     -> adds o_misaligned; a start with i_addr[1:0]!=0 completes without a memory access
//   not defined -> i_addr[1:0] is ignored and every access is word-aligned

module atomic_unit #(
    parameter int XLEN      = 32,
    parameter int RESV_GRAN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_resv_clr,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_rd_data,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_rd,
    output logic            o_mem_wr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_ack,
    output logic [4:0]      o_alu_op,
    output logic [XLEN-1:0] o_alu_s1,
    output logic [XLEN-1:0] o_alu_s2,
    input  logic [XLEN-1:0] i_alu_res
`ifdef ATOMIC_MISALIGN_EN
    ,
    output logic            o_misaligned
`endif
);

    // funct5 encodings of the RV32A operations
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    // sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]               state;
    logic [4:0]               op_q;
    logic [XLEN-1:0]          addr_q;
    logic [XLEN-1:0]          rs2_q;
    logic [XLEN-1:0]          word_q;
    logic [XLEN-1:0]          rd_q;
    logic                     resv_valid;
    logic [XLEN-1:RESV_GRAN]  resv_gran;

    logic [4:0]               start_op;
    logic                     start_mis;
    logic                     start_sc_ok;
    logic                     is_lr;
    logic                     is_sc;
    logic                     load_ack;
    logic                     store_ack;
    logic                     take_start;

    // Anything outside the defined funct5 set behaves as a swap, and the alu sees that same code
    function automatic logic [4:0] norm_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: norm_op = op;
            default:                          norm_op = OP_SWAP;
        endcase
    endfunction

    assign start_op    = norm_op(i_op);
    assign take_start  = (state == ST_IDLE) && i_start;
    assign start_sc_ok = resv_valid && (resv_gran == i_addr[XLEN-1:RESV_GRAN]);
    assign is_lr       = (op_q == OP_LR);
    assign is_sc       = (op_q == OP_SC);
    assign load_ack    = (state == ST_LOAD) && i_mem_ack;
    assign store_ack   = (state == ST_STORE) && i_mem_ack;

`ifdef ATOMIC_MISALIGN_EN
    assign start_mis = (i_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsb;
    assign start_mis       = 1'b0;
    assign unused_addr_lsb = ^i_addr[1:0];
`endif

    // Main sequencer: operand latching, state progression and the rd value
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= 5'd0;
            addr_q <= '0;
            rs2_q  <= '0;
            word_q <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        op_q   <= start_op;
                        addr_q <= i_addr;
                        rs2_q  <= i_rs2;
                        if (start_mis) begin
                            state <= ST_DONE;
                        end else if (start_op == OP_SC) begin
                            if (start_sc_ok) begin
                                state <= ST_STORE;
                            end else begin
                                state <= ST_DONE;
                                rd_q  <= {{(XLEN-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_mem_ack) begin
                        word_q <= i_mem_rdata;
                        rd_q   <= i_mem_rdata;
                        state  <= is_lr ? ST_DONE : ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (i_mem_ack) begin
                        state <= ST_DONE;
                        if (is_sc) begin
                            rd_q <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reservation tracking; an external clear outranks a set or clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            resv_valid <= 1'b0;
            resv_gran  <= '0;
        end else if (i_resv_clr) begin
            resv_valid <= 1'b0;
        end else begin
            if (take_start && !start_mis && (start_op == OP_SC) && !start_sc_ok) begin
                resv_valid <= 1'b0;
            end
            if (load_ack && is_lr) begin
                resv_valid <= 1'b1;
                resv_gran  <= addr_q[XLEN-1:RESV_GRAN];
            end
            if (store_ack) begin
                if (is_sc) begin
                    resv_valid <= 1'b0;
                end else if (resv_valid && (resv_gran == addr_q[XLEN-1:RESV_GRAN])) begin
                    resv_valid <= 1'b0;
                end
            end
        end
    end

`ifdef ATOMIC_MISALIGN_EN
    // Misalignment flag rides alongside the single DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            o_misaligned <= 1'b0;
        end else if (take_start && start_mis) begin
            o_misaligned <= 1'b1;
        end else begin
            o_misaligned <= 1'b0;
        end
    end
`endif

    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_DONE);
    assign o_mem_rd    = (state == ST_LOAD);
    assign o_mem_wr    = (state == ST_STORE);
    assign o_mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign o_mem_wdata = (state == ST_STORE) ? (is_sc ? rs2_q : i_alu_res) : '0;
    assign o_rd_data   = rd_q;
    assign o_alu_op    = op_q;
    assign o_alu_s1    = rs2_q;
    assign o_alu_s2    = word_q;

endmodule

// File: tb/tb_atomic_unit.sv
// tb/tb_atomic_unit.sv - self-checking bench for atomic_unit with memory, alu and reservation model

module tb_atomic_unit;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] SWAP = 5'b00001;
    localparam logic [4:0] LR   = 5'b00010;
    localparam logic [4:0] SC   = 5'b00011;
    localparam logic [4:0] XOR  = 5'b00100;
    localparam logic [4:0] OR   = 5'b01000;
    localparam logic [4:0] AND  = 5'b01100;
    localparam logic [4:0] MIN  = 5'b10000;
    localparam logic [4:0] MAX  = 5'b10100;
    localparam logic [4:0] MINU = 5'b11000;
    localparam logic [4:0] MAXU = 5'b11100;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [4:0]  i_op;
    logic [31:0] i_addr;
    logic [31:0] i_rs2;
    logic        i_resv_clr;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rd_data;
    logic [31:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic [4:0]  o_alu_op;
    logic [31:0] o_alu_s1;
    logic [31:0] o_alu_s2;
    logic [31:0] i_alu_res;
`ifdef ATOMIC_MISALIGN_EN
    logic        o_misaligned;
`endif

    always #5 clk = ~clk;

    atomic_unit dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_addr      (i_addr),
        .i_rs2       (i_rs2),
        .i_resv_clr  (i_resv_clr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_data   (o_rd_data),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rd    (o_mem_rd),
        .o_mem_wr    (o_mem_wr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .o_alu_op    (o_alu_op),
        .o_alu_s1    (o_alu_s1),
        .o_alu_s2    (o_alu_s2),
        .i_alu_res   (i_alu_res)
`ifdef ATOMIC_MISALIGN_EN
        ,
        .o_misaligned(o_misaligned)
`endif
    );

    int checks = 0;
    int errors = 0;

    // memory seen by the DUT, and the model's view of what it must contain
    logic [31:0] dmem [0:1023];
    logic [31:0] mmem [0:1023];
    int          mem_delay = 0;
    int          wait_cnt = 0;
    int          wr_count = 0;

    // model reservation
    bit          m_valid;
    logic [29:0] m_gran;

    // expectations shared with the compare process
    logic [31:0] exp_addr;
    logic [4:0]  exp_op;
    logic [31:0] exp_rs2;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    bit          exp_rd_valid;
    bit          exp_mis;
    bit          armed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Architectural AMO result: f(memory word, rs2)
    function automatic logic [31:0] amo_fn(input logic [4:0] op, input logic [31:0] mem,
                                           input logic [31:0] rs2);
        case (op)
            ADD:     amo_fn = mem + rs2;
            XOR:     amo_fn = mem ^ rs2;
            OR:      amo_fn = mem | rs2;
            AND:     amo_fn = mem & rs2;
            MIN:     amo_fn = ($signed(mem) < $signed(rs2)) ? mem : rs2;
            MAX:     amo_fn = ($signed(mem) > $signed(rs2)) ? mem : rs2;
            MINU:    amo_fn = (mem < rs2) ? mem : rs2;
            MAXU:    amo_fn = (mem > rs2) ? mem : rs2;
            default: amo_fn = rs2;
        endcase
    endfunction

    function automatic bit known_op(input logic [4:0] op);
        return op inside {ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU};
    endfunction

    // stand-in for atomic_alu
    assign i_alu_res = amo_fn(o_alu_op, o_alu_s2, o_alu_s1);

    // memory responder: ack after mem_delay wait cycles, decided away from the clock edge
    always @(negedge clk) begin
        if (o_mem_rd || o_mem_wr) begin
            if (wait_cnt == mem_delay) begin
                i_mem_ack = 1'b1;
                i_mem_rdata = o_mem_rd ? dmem[int'(o_mem_addr[11:2])] : 32'h0;
                if (o_mem_wr) begin
                    dmem[int'(o_mem_addr[11:2])] = o_mem_wdata;
                    wr_count++;
                end
                wait_cnt = 0;
            end else begin
                i_mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            i_mem_rdata = 32'h0;
            wait_cnt = 0;
        end
    end

    // compare process: every cycle the DUT is out of reset
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", 32'(o_mem_rd && o_mem_wr), 32'd0);
            if (o_mem_rd || o_mem_wr) begin
                check("mem_addr", o_mem_addr, exp_addr);
                check("alu_op", 32'(o_alu_op), 32'(exp_op));
                check("alu_s1", o_alu_s1, exp_rs2);
            end
            if (o_mem_wr) begin
                check("mem_wdata", o_mem_wdata, exp_wdata);
            end
            if (o_done) begin
                check("done_expected", 32'(armed), 32'd1);
                if (armed && exp_rd_valid) begin
                    check("rd_data", o_rd_data, exp_rd);
                end
            end
`ifdef ATOMIC_MISALIGN_EN
            check("misaligned", 32'(o_misaligned), 32'(o_done && exp_mis));
`endif
        end
    end

    task automatic setmem(input logic [31:0] addr, input logic [31:0] val);
        dmem[int'(addr[11:2])] = val;
        mmem[int'(addr[11:2])] = val;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_resv_clr = 1'b1;
        @(negedge clk);
        i_resv_clr = 1'b0;
        m_valid = 1'b0;
    endtask

    // Run one instruction against the model; lat = cycles from the start edge to o_done
    task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input int d, input bit poke, input bit hold_clr, output int lat);
        logic [4:0]  nop;
        logic [31:0] old;
        int          idx;
        int          writes;
        int          exp_lat;
        int          wc0;
        bit          ok;
        idx = int'(addr[11:2]);
        old = mmem[idx];
        nop = known_op(op) ? op : SWAP;
        writes = 0;
        if (nop == LR) begin
            exp_rd = old;
            exp_lat = 2 + d;
            m_valid = 1'b1;
            m_gran = addr[31:2];
        end else if (nop == SC) begin
            ok = m_valid && (m_gran == addr[31:2]);
            m_valid = 1'b0;
            if (ok) begin
                exp_rd = 32'd0;
                exp_wdata = rs2;
                mmem[idx] = rs2;
                writes = 1;
                exp_lat = 2 + d;
            end else begin
                exp_rd = 32'd1;
                exp_lat = 1;
            end
        end else begin
            exp_rd = old;
            exp_wdata = amo_fn(nop, old, rs2);
            mmem[idx] = exp_wdata;
            writes = 1;
            exp_lat = 3 + 2 * d;
            if (m_valid && (m_gran == addr[31:2])) m_valid = 1'b0;
        end
        if (hold_clr) m_valid = 1'b0;
        exp_addr = {addr[31:2], 2'b00};
        exp_op = nop;
        exp_rs2 = rs2;
        exp_rd_valid = 1'b1;
        armed = 1'b1;
        mem_delay = d;
        wc0 = wr_count;

        @(negedge clk);
        i_start = 1'b1;
        i_op = op;
        i_addr = addr;
        i_rs2 = rs2;
        i_resv_clr = hold_clr;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0 && poke) begin
                i_op = ADD;
                i_addr = addr ^ 32'h40;
                i_rs2 = ~rs2;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                lat = k + 1;
                break;
            end
        end
        i_start = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual no o_done required o_done op %b addr %h", op, addr);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("busy_in_done", 32'(o_busy), 32'd1);
        end
        check("mem_word", dmem[idx], mmem[idx]);
        check("write_count", 32'(wr_count - wc0), 32'(writes));
        @(negedge clk);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("idle_after", 32'(o_busy), 32'd0);
        armed = 1'b0;
        i_resv_clr = 1'b0;
    endtask

    initial begin
        int lat;
        int wc0;
        int seen;
        logic [4:0]  ops [5];
        logic [31:0] mv [5];
        logic [31:0] rv [5];
        ops = '{XOR, OR, AND, MAX, MAXU};
        mv  = '{32'hF0F0_1234, 32'h0000_00F0, 32'hFFFF_0F0F, 32'h8000_0000, 32'h8000_0000};
        rv  = '{32'h0FF0_FFFF, 32'h0000_0F0F, 32'h1234_5678, 32'h0000_0005, 32'h0000_0005};

        rst = 1'b1;
        i_start = 1'b0;
        i_op = 5'd0;
        i_addr = 32'd0;
        i_rs2 = 32'd0;
        i_resv_clr = 1'b0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'd0;
        armed = 1'b0;
        exp_rd_valid = 1'b1;
        exp_mis = 1'b0;
        m_valid = 1'b0;
        m_gran = '0;
        exp_addr = '0;
        exp_op = '0;
        exp_rs2 = '0;
        exp_wdata = '0;
        exp_rd = '0;
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = 32'h1000 + 32'(i);
            mmem[i] = 32'h1000 + 32'(i);
        end
        setmem(32'h100, 32'd5);
        setmem(32'h104, 32'hFFFF_FFFF);
        setmem(32'h108, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        check("rst_mem_wr", 32'(o_mem_wr), 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        check("rst_alu_op", 32'(o_alu_op), 32'd0);
        check("rst_alu_s1", o_alu_s1, 32'd0);
        check("rst_alu_s2", o_alu_s2, 32'd0);
`ifdef ATOMIC_MISALIGN_EN
        check("rst_misaligned", 32'(o_misaligned), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // AMOADD and the signed/unsigned min pair, pinned with literals
        do_op(ADD, 32'h100, 32'd3, 0, 1'b0, 1'b0, lat);
        check("amoadd_lat_lit", 32'(lat), 32'd3);
        check("amoadd_rd_lit", o_rd_data, 32'd5);
        check("amoadd_mem_lit", dmem[64], 32'd8);
        do_op(MIN, 32'h104, 32'd1, 0, 1'b0, 1'b0, lat);
        check("amomin_mem_lit", dmem[65], 32'hFFFF_FFFF);
        do_op(MINU, 32'h108, 32'd1, 0, 1'b0, 1'b0, lat);
        check("amominu_mem_lit", dmem[66], 32'd1);

        // remaining AMO kinds with a one-cycle-wait memory
        for (int i = 0; i < 5; i++) begin
            setmem(32'h140 + 32'(4 * i), mv[i]);
            do_op(ops[i], 32'h140 + 32'(4 * i), rv[i], 1, 1'b0, 1'b0, lat);
        end
        check("amomax_mem_lit", dmem[83], 32'd5);
        check("amomaxu_mem_lit", dmem[84], 32'h8000_0000);

        // LR/SC success then a second SC that must fail
        setmem(32'h200, 32'h1234);
        do_op(LR, 32'h200, 32'd0, 0, 1'b0, 1'b0, lat);
        check("lr_lat_lit", 32'(lat), 32'd2);
        check("lr_rd_lit", o_rd_data, 32'h1234);
        do_op(SC, 32'h200, 32'd7, 0, 1'b0, 1'b0, lat);
        check("sc_ok_rd_lit", o_rd_data, 32'd0);
        check("sc_ok_mem_lit", dmem[128], 32'd7);
        do_op(SC, 32'h200, 32'd8, 0, 1'b0, 1'b0, lat);
        check("sc_again_rd_lit", o_rd_data, 32'd1);
        check("sc_fail_lat_lit", 32'(lat), 32'd1);

        // external clear between LR and SC
        do_op(LR, 32'h200, 32'd0, 0, 1'b0, 1'b0, lat);
        pulse_clr();
        wc0 = wr_count;
        do_op(SC, 32'h200, 32'd9, 0, 1'b0, 1'b0, lat);
        check("sc_after_clr_rd_lit", o_rd_data, 32'd1);
        check("sc_after_clr_nowrite", 32'(wr_count - wc0), 32'd0);
        check("sc_after_clr_mem_lit", dmem[128], 32'd7);

        // clear held while the LR sets its reservation
        do_op(LR, 32'h200, 32'd0, 2, 1'b0, 1'b1, lat);
        do_op(SC, 32'h200, 32'd10, 0, 1'b0, 1'b0, lat);

        // a failing SC elsewhere still kills the reservation
        do_op(LR, 32'h200, 32'd0, 0, 1'b0, 1'b0, lat);
        do_op(SC, 32'h204, 32'd11, 0, 1'b0, 1'b0, lat);
        do_op(SC, 32'h200, 32'd12, 0, 1'b0, 1'b0, lat);
        check("sc_after_fail_rd_lit", o_rd_data, 32'd1);

        // AMO store into the reserved granule clears it; a neighbouring word does not
        do_op(LR, 32'h210, 32'd0, 0, 1'b0, 1'b0, lat);
        do_op(ADD, 32'h210, 32'd1, 0, 1'b0, 1'b0, lat);
        do_op(SC, 32'h210, 32'd13, 0, 1'b0, 1'b0, lat);
        do_op(LR, 32'h220, 32'd0, 0, 1'b0, 1'b0, lat);
        do_op(ADD, 32'h224, 32'd1, 0, 1'b0, 1'b0, lat);
        do_op(SC, 32'h220, 32'd14, 0, 1'b0, 1'b0, lat);
        check("sc_neighbour_rd_lit", o_rd_data, 32'd0);

        // unknown funct5 behaves as swap
        do_op(5'b00101, 32'h110, 32'hABCD, 0, 1'b0, 1'b0, lat);
        check("unknown_op_mem_lit", dmem[68], 32'hABCD);

        // waited swap with a start request poked while busy; waited LR/SC pair
        do_op(SWAP, 32'h120, 32'h5555_AAAA, 3, 1'b1, 1'b0, lat);
        check("swap_wait_lat_lit", 32'(lat), 32'd9);
        do_op(LR, 32'h230, 32'd0, 2, 1'b0, 1'b0, lat);
        do_op(SC, 32'h230, 32'h77, 2, 1'b0, 1'b0, lat);

`ifndef ATOMIC_MISALIGN_EN
        // low address bits ignored: 0x103 targets the word at 0x100 (holding 8)
        do_op(ADD, 32'h103, 32'd1, 0, 1'b0, 1'b0, lat);
        check("lsb_ignored_mem_lit", dmem[64], 32'd9);
`endif

        // reset in the middle of a waited STORE
        setmem(32'h300, 32'h11);
        do_op(LR, 32'h300, 32'd0, 0, 1'b0, 1'b0, lat);
        exp_addr = 32'h300;
        exp_op = SWAP;
        exp_rs2 = 32'h22;
        exp_wdata = 32'h22;
        armed = 1'b0;
        mem_delay = 4;
        wc0 = wr_count;
        @(negedge clk);
        i_start = 1'b1;
        i_op = SWAP;
        i_addr = 32'h300;
        i_rs2 = 32'h22;
        @(negedge clk);
        i_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_mem_wr) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_test_store_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_mem_wr", 32'(o_mem_wr), 32'd0);
        check("midrst_mem_rd", 32'(o_mem_rd), 32'd0);
        rst = 1'b0;
        m_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_nowrite", 32'(wr_count - wc0), 32'd0);
        check("midrst_mem_lit", dmem[192], 32'h11);
        do_op(SC, 32'h300, 32'h33, 0, 1'b0, 1'b0, lat);
        check("sc_after_rst_rd_lit", o_rd_data, 32'd1);

`ifdef ATOMIC_MISALIGN_EN
        // misaligned AMOOR completes at once with no memory traffic
        exp_mis = 1'b1;
        exp_rd_valid = 1'b0;
        armed = 1'b1;
        seen = 0;
        lat = -1;
        @(negedge clk);
        i_start = 1'b1;
        i_op = OR;
        i_addr = 32'h102;
        i_rs2 = 32'hF0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_mem_rd || o_mem_wr) seen++;
            if (o_done) begin
                lat = k + 1;
                check("mis_flag_lit", 32'(o_misaligned), 32'd1);
                break;
            end
        end
        check("mis_lat_lit", 32'(lat), 32'd1);
        check("mis_no_access", 32'(seen), 32'd0);
        @(negedge clk);
        armed = 1'b0;
        exp_mis = 1'b0;
        exp_rd_valid = 1'b1;
        check("mis_mem_lit", dmem[64], 32'd8);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
